// File: rtl/jtkunio_sdram_pkg.sv
// Shared definitions for the Kunio SDRAM responder: sizes, FSM states,
// the return-pipe tag record and a bank decode helper.
package jtkunio_sdram_pkg;

    localparam int NBANK = 4;
    localparam int AW    = 22;
    localparam int DW    = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WAIT = 2'd2,
        ST_PROG = 2'd3
    } state_t;

    // One entry of the return pipe, travelling alongside each memory read
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
        logic prog;
    } tag_t;

    function automatic logic [NBANK-1:0] bank_onehot(input logic [1:0] idx);
        bank_onehot = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/jtkunio_sdram_resp_if.sv
// Bank request, download port and memory port of the SDRAM responder.
// The slave side is the responder, the master side is the game wrapper
// together with the memory behind it.
interface jtkunio_sdram_resp_if;
    import jtkunio_sdram_pkg::*;

    logic [AW-1:0]    ba0_addr;
    logic [AW-1:0]    ba1_addr;
    logic [AW-1:0]    ba2_addr;
    logic [AW-1:0]    ba3_addr;
    logic [NBANK-1:0] ba_rd;
    logic [NBANK-1:0] ba_ack;
    logic [NBANK-1:0] ba_dst;
    logic [NBANK-1:0] ba_dok;
    logic [NBANK-1:0] ba_rdy;
    logic [DW-1:0]    data_read;

    logic [AW-1:0]    prog_addr;
    logic [DW-1:0]    prog_data;
    logic [1:0]       prog_mask;
    logic [1:0]       prog_ba;
    logic             prog_we;
    logic             prog_rd;
    logic             prog_ack;
    logic             prog_rdy;

    logic             mem_rd;
    logic             mem_we;
    logic [AW+1:0]    mem_addr;
    logic [DW-1:0]    mem_din;
    logic [1:0]       mem_mask;
    logic [DW-1:0]    mem_dout;

    modport slave (
        input  ba0_addr, ba1_addr, ba2_addr, ba3_addr, ba_rd,
        input  prog_addr, prog_data, prog_mask, prog_ba, prog_we, prog_rd,
        input  mem_dout,
        output ba_ack, ba_dst, ba_dok, ba_rdy, data_read,
        output prog_ack, prog_rdy,
        output mem_rd, mem_we, mem_addr, mem_din, mem_mask
    );

    modport master (
        output ba0_addr, ba1_addr, ba2_addr, ba3_addr, ba_rd,
        output prog_addr, prog_data, prog_mask, prog_ba, prog_we, prog_rd,
        output mem_dout,
        input  ba_ack, ba_dst, ba_dok, ba_rdy, data_read,
        input  prog_ack, prog_rdy,
        input  mem_rd, mem_we, mem_addr, mem_din, mem_mask
    );

endinterface

// File: rtl/jtkunio_sdram_resp_rr_arb.sv
// Four-way round-robin arbiter. The search starts at the bank after the
// one served last, so a continuously requesting bank cannot starve others.
module jtkunio_rr_arb
    import jtkunio_sdram_pkg::*;
(
    input  logic [NBANK-1:0] i_req,
    input  logic [1:0]       i_last,
    output logic [NBANK-1:0] o_gnt,
    output logic [1:0]       o_idx,
    output logic             o_any
);

    logic [1:0] w_cand;
    logic       w_hit;

    // Scan last+1 .. last+4 and keep the first requesting bank
    always_comb begin
        o_idx  = i_last;
        o_any  = 1'b0;
        w_cand = 2'd0;
        w_hit  = 1'b0;
        for (int i = 1; i <= NBANK; i++) begin
            w_cand = i_last + 2'(i);
            w_hit  = i_req[w_cand] & ~o_any;
            o_idx  = w_hit ? w_cand : o_idx;
            o_any  = o_any | w_hit;
        end
        o_gnt = o_any ? bank_onehot(o_idx) : 4'b0000;
    end

endmodule

// File: rtl/jtkunio_sdram_resp.sv
// Serving end of the Kunio four-bank ROM read protocol. Grants one bank
// (or the download port) at a time, issues BURST fixed-latency reads and
// returns the words with dst/dok/rdy strobes from a tag pipeline.
module jtkunio_sdram_resp
    import jtkunio_sdram_pkg::*;
#(
    parameter int BURST   = 2,
    parameter int LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    jtkunio_sdram_resp_if.slave   bus
);

    localparam logic [1:0] LAST_BEAT = 2'(BURST - 1);

    state_t           r_state, w_state_nx;
    logic [1:0]       r_cnt, w_cnt_nx;
    logic [1:0]       r_bank, w_bank_nx;
    logic [1:0]       r_last, w_last_nx;
    logic [AW-1:0]    r_addr, w_addr_nx;
    logic             r_pwe, w_pwe_nx;
    logic [DW-1:0]    r_pdata, w_pdata_nx;
    logic [1:0]       r_pmask, w_pmask_nx;

    logic [NBANK-1:0] r_ack, w_ack_nx;
    logic             r_prog_ack, w_prog_ack_nx;
    logic             r_mem_rd, w_mem_rd_nx;
    logic             r_mem_we, w_mem_we_nx;
    logic [AW+1:0]    r_mem_addr, w_mem_addr_nx;
    logic [DW-1:0]    r_mem_din, w_mem_din_nx;
    logic [1:0]       r_mem_mask, w_mem_mask_nx;

    tag_t             w_tag_in;
    tag_t             r_tag [LATENCY];
    tag_t             w_out;
    logic [NBANK-1:0] r_dst, r_dok, r_rdy;
    logic             r_prog_rdy;
    logic             r_dvalid;

    logic [NBANK-1:0] w_gnt;
    logic [1:0]       w_idx;
    logic             w_any;
    logic [AW-1:0]    w_req_addr;

    jtkunio_rr_arb u_arb (
        .i_req  (bus.ba_rd),
        .i_last (r_last),
        .o_gnt  (w_gnt),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    // Address of the bank that would win arbitration this cycle
    always_comb begin
        case (w_idx)
            2'd0:    w_req_addr = bus.ba0_addr;
            2'd1:    w_req_addr = bus.ba1_addr;
            2'd2:    w_req_addr = bus.ba2_addr;
            2'd3:    w_req_addr = bus.ba3_addr;
            default: w_req_addr = bus.ba0_addr;
        endcase
    end

    // Next state and next registered outputs of the transaction FSM
    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_bank_nx     = r_bank;
        w_last_nx     = r_last;
        w_addr_nx     = r_addr;
        w_pwe_nx      = r_pwe;
        w_pdata_nx    = r_pdata;
        w_pmask_nx    = r_pmask;
        w_ack_nx      = 4'b0000;
        w_prog_ack_nx = 1'b0;
        w_mem_rd_nx   = 1'b0;
        w_mem_we_nx   = 1'b0;
        w_mem_addr_nx = r_mem_addr;
        w_mem_din_nx  = 16'h0000;
        w_mem_mask_nx = 2'b00;
        w_tag_in      = '0;
        case (r_state)
            ST_IDLE: begin
                // the download port always beats the banks
                if (bus.prog_we || bus.prog_rd) begin
                    w_state_nx    = ST_PROG;
                    w_prog_ack_nx = 1'b1;
                    w_bank_nx     = bus.prog_ba;
                    w_addr_nx     = bus.prog_addr;
                    w_pwe_nx      = bus.prog_we;
                    w_pdata_nx    = bus.prog_data;
                    w_pmask_nx    = bus.prog_mask;
                end else if (w_any) begin
                    w_state_nx = ST_RD;
                    w_ack_nx   = w_gnt;
                    w_bank_nx  = w_idx;
                    w_last_nx  = w_idx;
                    w_addr_nx  = w_req_addr;
                    w_cnt_nx   = 2'd0;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_RD: begin
                // word address wraps inside the bank, bank bits stay put
                w_mem_rd_nx   = 1'b1;
                w_mem_addr_nx = {r_bank, r_addr + AW'(r_cnt)};
                w_tag_in      = '{valid: 1'b1, first: (r_cnt == 2'd0),
                                  last: (r_cnt == LAST_BEAT), prog: 1'b0};
                if (r_cnt == LAST_BEAT) begin
                    w_state_nx = ST_WAIT;
                    w_cnt_nx   = 2'd0;
                end else begin
                    w_cnt_nx   = r_cnt + 2'd1;
                end
            end
            ST_PROG: begin
                w_mem_we_nx   = r_pwe;
                w_mem_rd_nx   = ~r_pwe;
                w_mem_addr_nx = {r_bank, r_addr};
                w_mem_din_nx  = r_pwe ? r_pdata : 16'h0000;
                w_mem_mask_nx = r_pwe ? r_pmask : 2'b00;
                w_tag_in      = '{valid: 1'b1, first: 1'b1, last: 1'b1, prog: 1'b1};
                w_state_nx    = ST_WAIT;
            end
            ST_WAIT: begin
                if ((|r_rdy) || r_prog_rdy) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_state_nx = ST_WAIT;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // FSM state, latched request and registered memory-side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 2'd0;
            r_bank     <= 2'd0;
            r_last     <= 2'd3;
            r_addr     <= '0;
            r_pwe      <= 1'b0;
            r_pdata    <= 16'h0000;
            r_pmask    <= 2'b00;
            r_ack      <= 4'b0000;
            r_prog_ack <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= 16'h0000;
            r_mem_mask <= 2'b00;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_bank     <= w_bank_nx;
            r_last     <= w_last_nx;
            r_addr     <= w_addr_nx;
            r_pwe      <= w_pwe_nx;
            r_pdata    <= w_pdata_nx;
            r_pmask    <= w_pmask_nx;
            r_ack      <= w_ack_nx;
            r_prog_ack <= w_prog_ack_nx;
            r_mem_rd   <= w_mem_rd_nx;
            r_mem_we   <= w_mem_we_nx;
            r_mem_addr <= w_mem_addr_nx;
            r_mem_din  <= w_mem_din_nx;
            r_mem_mask <= w_mem_mask_nx;
        end
    end

    // Tags shift in step with the memory latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= w_tag_in;
            for (int i = 1; i < LATENCY; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign w_out = r_tag[LATENCY-1];

    // Return strobes line up with the cycle mem_dout carries the word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dst      <= 4'b0000;
            r_dok      <= 4'b0000;
            r_rdy      <= 4'b0000;
            r_prog_rdy <= 1'b0;
            r_dvalid   <= 1'b0;
        end else begin
            r_dok      <= (w_out.valid & ~w_out.prog) ? bank_onehot(r_bank) : 4'b0000;
            r_dst      <= (w_out.valid & ~w_out.prog & w_out.first) ? bank_onehot(r_bank) : 4'b0000;
            r_rdy      <= (w_out.valid & ~w_out.prog & w_out.last) ? bank_onehot(r_bank) : 4'b0000;
            r_prog_rdy <= w_out.valid & w_out.prog;
            r_dvalid   <= w_out.valid & ~(w_out.prog & r_pwe);
        end
    end

    assign bus.ba_ack    = r_ack;
    assign bus.ba_dst    = r_dst;
    assign bus.ba_dok    = r_dok;
    assign bus.ba_rdy    = r_rdy;
    assign bus.data_read = r_dvalid ? bus.mem_dout : 16'h0000;
    assign bus.prog_ack  = r_prog_ack;
    assign bus.prog_rdy  = r_prog_rdy;
    assign bus.mem_rd    = r_mem_rd;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_din   = r_mem_din;
    assign bus.mem_mask  = r_mem_mask;

endmodule

// File: doc/jtkunio_sdram_resp.md
# jtkunio_sdram_resp

Responder for the four-bank ROM read protocol used by the Kunio SDRAM wrapper: it takes `ba_rd`/`baN_addr` requests plus the download write port, arbitrates them, drives a fixed-latency 16-bit memory port, and returns `ba_ack`/`ba_dst`/`ba_dok`/`ba_rdy`/`data_read`. It sits between the game's SDRAM wrapper and the physical memory model or controller. It is the serving end of the same handshake the ROM slots initiate.

## Interface
- `BURST`, 2, words returned per bank request (1..4)
- `LATENCY`, 2, cycles from `mem_rd` to the matching `mem_dout` (1..7)
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `ba0_addr`..`ba3_addr`  in  22 each  word address per bank
- `ba_rd`  in  4  read request per bank, held until acked
- `ba_ack`  out  4  one-cycle request accept
- `ba_dst`  out  4  first data word valid
- `ba_dok`  out  4  any data word valid
- `ba_rdy`  out  4  last data word valid
- `data_read`  out  16  returned word
- `prog_addr`  in  22; `prog_data` in 16; `prog_mask` in 2 (active low); `prog_ba` in 2; `prog_we` in 1; `prog_rd` in 1
- `prog_ack`  out  1; `prog_rdy`  out  1
- `mem_rd`, `mem_we`  out  1; `mem_addr` out 24 ({bank, word}); `mem_din` out 16; `mem_mask` out 2; `mem_dout` in 16

## Operation
- States: IDLE, RD (issue BURST reads), WAIT (drain), PROG.
- IDLE: if `prog_we|prog_rd` → PROG (priority over banks). Else if any `ba_rd` → grant by round-robin starting at (last served bank + 1) mod 4; latch address; `ba_ack[g]`=1 for this cycle; → RD.
- RD: `mem_rd`=1 for BURST consecutive cycles, addresses latched+0..BURST-1 (22-bit wrap, bank bits unchanged); → WAIT.
- Return pipe: a LATENCY-deep shift of {valid, first, last} tags; on each returned word `data_read`=`mem_dout`, `ba_dok[g]`=1; `ba_dst[g]` on first, `ba_rdy[g]` on last. WAIT → IDLE in the cycle after `ba_rdy`.
- PROG: `prog_ack`=1 one cycle; `prog_we` → `mem_we`=1, `mem_din`/`mem_mask` from prog; `prog_rd` → `mem_rd`=1. `prog_rdy`=1 exactly LATENCY cycles later; no `ba_*` strobes; then IDLE.
- A `ba_rd` dropped before ack is never served. After ack, burst completes regardless of `ba_rd`.
- At most one transaction in flight; at most one `ba_*` bit set at a time.

## Timing
- Reset: all outputs 0, round-robin pointer = bank 3 (bank 0 first), state IDLE. Async assert clears in-flight burst; no strobes after release.
- Ack at cycle T (request visible at T in IDLE). `mem_rd` T+1..T+BURST. `ba_dst` at T+1+LATENCY, `ba_rdy` at T+BURST+LATENCY.
- `ba_dok` contiguous for BURST cycles; with BURST=1 dst, dok, rdy coincide.
- Next ack no earlier than T+BURST+LATENCY+1.
- `prog_we` and `ba_rd` same cycle in IDLE: prog wins, bank waits.

## Structure
- Shared package `jtkunio_sdram_pkg`: state enum, bank count 4, address width 22, data width 16.
- Sub-module `jtkunio_rr_arb` (4-way round-robin, request in, one-hot grant plus index out).
- Return tag pipeline inline.

## Test plan
- Reset then `ba_rd`=0010, `ba1_addr`=0x001234, mem returns 0xA5A5, 0x5A5A → `ba_ack`=0010 at T, `mem_addr`=0x401234/0x401235, dst+dok at T+3, rdy+dok at T+4 with 0x5A5A.
- `ba_rd`=1111 held → service order 0,1,2,3,0; exactly one ack per burst.
- `prog_we`=1 with `ba_rd`=0001 same cycle → `prog_ack` first, `mem_we`=1, `mem_din`=prog_data, `prog_rdy` at +LATENCY, then bank 0 acked.
- `ba_rd[2]` pulsed 1 cycle while bank 0 busy → never acked; `ba3_addr`=0x3FFFFF with BURST=2 → second address 0xC00000.
- `rst_n` low mid-burst (after ack, before dst) → all outputs 0 immediately; no dok/rdy after release.
- BURST=1, LATENCY=1 → dst/dok/rdy on same single cycle, T+2.
